// File: rtl/sr_math_arbiter_pkg.sv
// Shared types and defaults for the two-port math unit arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package sr_math_arbiter_pkg;

  localparam int DEF_OP_W  = 8;
  localparam int DEF_RES_W = 16;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_RUN    = 2'd3
  } arbState_t;

  // Round-robin pick between two requesters: a lone requester always wins,
  // on contention the port that did not win last time gets the grant.
  function automatic logic rrPick(input logic [1:0] valid, input logic lastGrant);
    logic pick;
    if (valid == 2'b11) begin
      pick = ~lastGrant;
    end else begin
      pick = valid[1];
    end
    return pick;
  endfunction

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin grant from {valid1, valid0} and the previous winner.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module sr_rr_arb2
  import sr_math_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       lastGrant,
  output logic       grant,
  output logic       grantValid
);

  // Grant index is only meaningful while grantValid is high.
  always_comb begin
    grant      = rrPick(valid, lastGrant);
    grantValid = |valid;
  end

endmodule

// File: rtl/sr_math_arbiter.sv
// Shares one multi-cycle math unit between two requesters with round-robin arbitration.
// Latency: handshake at T -> math_start at T+1; response pulse one cycle after math_busy falls.
// Backpressure: one job in flight; both readys stay low until the FSM is idle and the unit is not busy.
module sr_math_arbiter
  import sr_math_arbiter_pkg::*;
#(
  parameter int OP_W         = DEF_OP_W,
  parameter int RES_W        = DEF_RES_W,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [OP_W-1:0]  req0_a,
  input  logic [OP_W-1:0]  req0_b,
  output logic             req0_ready,
  output logic             resp0_valid,
  output logic [RES_W-1:0] resp0_res,
  input  logic             req1_valid,
  input  logic [OP_W-1:0]  req1_a,
  input  logic [OP_W-1:0]  req1_b,
  output logic             req1_ready,
  output logic             resp1_valid,
  output logic [RES_W-1:0] resp1_res,
  output logic             math_start,
  output logic [OP_W-1:0]  math_a,
  output logic [OP_W-1:0]  math_b,
  input  logic             math_busy,
  input  logic [RES_W-1:0] math_res,
  output logic             arb_busy,
  output logic             err_timeout
);

  localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  arbState_t        state;
  logic             lastGrant;
  logic             owner;
  logic [CNT_W-1:0] timeoutCnt;
  logic             grant;
  logic             grantValid;
  logic             accept;
  logic             timedOut;
  logic             finish;

  sr_rr_arb2 uRrArb (
    .valid      ({req1_valid, req0_valid}),
    .lastGrant  (lastGrant),
    .grant      (grant),
    .grantValid (grantValid)
  );

  // Offer the granted port only when a job can be launched right away; a unit
  // still busy from before a reset blocks acceptance.
  always_comb begin
    accept     = (state == ARB_IDLE) && !math_busy && grantValid;
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    arb_busy   = (state != ARB_IDLE);
    timedOut   = (state == ARB_WAIT) && !math_busy && (timeoutCnt == CNT_LAST);
    finish     = timedOut || ((state == ARB_RUN) && !math_busy);
  end

  // Job sequencing: latch operands, launch, wait for busy (bounded), run to completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      lastGrant   <= 1'b1;
      owner       <= 1'b0;
      timeoutCnt  <= '0;
      math_start  <= 1'b0;
      math_a      <= '0;
      math_b      <= '0;
      err_timeout <= 1'b0;
    end else begin
      math_start <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (accept) begin
            math_a     <= grant ? req1_a : req0_a;
            math_b     <= grant ? req1_b : req0_b;
            owner      <= grant;
            lastGrant  <= grant;
            math_start <= 1'b1;
            state      <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          timeoutCnt <= '0;
          state      <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (math_busy) begin
            state <= ARB_RUN;
          end else if (timedOut) begin
            // Unit never acknowledged: flag it and complete with whatever it drives.
            err_timeout <= 1'b1;
            state       <= ARB_IDLE;
          end else begin
            timeoutCnt <= timeoutCnt + CNT_W'(1);
          end
        end
        ARB_RUN: begin
          if (!math_busy) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Return the result to the port owning the finishing job; the pulse lands in
  // the first IDLE cycle so a new handshake can overlap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_res   <= '0;
      resp1_res   <= '0;
    end else begin
      resp0_valid <= finish && !owner;
      resp1_valid <= finish && owner;
      if (finish && !owner) begin
        resp0_res <= math_res;
      end
      if (finish && owner) begin
        resp1_res <= math_res;
      end
    end
  end

endmodule

// File: tb/tb_sr_math_arbiter.sv
// Randomised self-checking bench for sr_math_arbiter with a transaction-level reference model.
// Latency: model predicts start at handshake+1 and response from the unit's busy profile.
// Backpressure: request queues hold valid and operands until the DUT handshakes.
module tb_sr_math_arbiter;

  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  localparam int BT    = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [OP_W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic             resp0_valid, resp1_valid;
  logic [RES_W-1:0] resp0_res, resp1_res;
  logic             math_start;
  logic [OP_W-1:0]  math_a, math_b;
  logic             math_busy;
  logic [RES_W-1:0] math_res;
  logic             arb_busy;
  logic             err_timeout;

  sr_math_arbiter #(.OP_W(OP_W), .RES_W(RES_W), .BUSY_TIMEOUT(BT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .resp0_valid (resp0_valid),
    .resp0_res   (resp0_res),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .resp1_valid (resp1_valid),
    .resp1_res   (resp1_res),
    .math_start  (math_start),
    .math_a      (math_a),
    .math_b      (math_b),
    .math_busy   (math_busy),
    .math_res    (math_res),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- math unit model ----------------
  int          cfgDelay = 1;
  int          cfgLen   = 3;
  bit          cfgNever = 1'b0;
  bit          forceBusy = 1'b0;
  bit          uActive = 1'b0;
  int          uT = 0;
  logic [15:0] uRes = '0;

  // busy is high in cycles start+cfgDelay .. start+cfgDelay+cfgLen-1
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      uActive = 1'b0;
      uRes    = '0;
    end else if (math_start) begin
      uActive = 1'b1;
      uT      = 0;
      uRes    = cfgNever ? 16'hBEEF : 16'(math_a) * 16'(math_b);
    end else if (uActive) begin
      uT++;
    end
    math_busy = (uActive && !cfgNever && uT >= cfgDelay && uT < cfgDelay + cfgLen) || forceBusy;
    math_res  = uRes;
  end

  // ---------------- request driver ----------------
  int q0a[$], q0b[$], q1a[$], q1b[$];
  bit hs0 = 1'b0, hs1 = 1'b0;

  always @(posedge clk) begin
    #1;
    if (hs0 && q0a.size() > 0) begin q0a.delete(0); q0b.delete(0); end
    if (hs1 && q1a.size() > 0) begin q1a.delete(0); q1b.delete(0); end
    req0_valid = (q0a.size() > 0);
    req0_a     = (q0a.size() > 0) ? 8'(q0a[0]) : 8'h0;
    req0_b     = (q0b.size() > 0) ? 8'(q0b[0]) : 8'h0;
    req1_valid = (q1a.size() > 0);
    req1_a     = (q1a.size() > 0) ? 8'(q1a[0]) : 8'h0;
    req1_b     = (q1b.size() > 0) ? 8'(q1b[0]) : 8'h0;
  end

  // ---------------- reference model + compare ----------------
  int          cyc = 0;
  int          freeAt = 0, startAt = -1, respAt = -1;
  bit          respPort = 1'b0;
  logic [15:0] pendRes = '0;
  bit          pendErr = 1'b0;
  logic [15:0] mRes0 = '0, mRes1 = '0;
  bit          mErr = 1'b0;
  bit          mLast = 1'b1;
  logic [7:0]  mA = '0, mB = '0;
  bit          idle, g, offer;

  int startCnt = 0, resp0Cnt = 0, resp1Cnt = 0, bothRdyCnt = 0, b2bCnt = 0, rdy0Cnt = 0;
  int lastHsCyc = 0, lastStartCyc = 0, lastResp0Cyc = 0, lastResp1Cyc = 0, errRiseCyc = 0;
  bit prevErr = 1'b0;
  int hsLog[$];

  always @(negedge clk) begin
    cyc++;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    if (!rst_n) begin
      freeAt = 0; startAt = -1; respAt = -1; mLast = 1'b1;
      mRes0 = '0; mRes1 = '0; mErr = 1'b0; mA = '0; mB = '0; prevErr = 1'b0;
      chk("rst_ready0", 32'(req0_ready), 0);
      chk("rst_ready1", 32'(req1_ready), 0);
      chk("rst_start", 32'(math_start), 0);
      chk("rst_resp0_valid", 32'(resp0_valid), 0);
      chk("rst_resp1_valid", 32'(resp1_valid), 0);
      chk("rst_err", 32'(err_timeout), 0);
      chk("rst_arb_busy", 32'(arb_busy), 0);
    end else begin
      if (cyc == respAt) begin
        if (respPort) mRes1 = pendRes; else mRes0 = pendRes;
        if (pendErr) mErr = 1'b1;
      end
      idle  = (cyc >= freeAt);
      g     = (req0_valid && req1_valid) ? !mLast : req1_valid;
      offer = idle && !math_busy && (req0_valid || req1_valid);
      chk("ready0", 32'(req0_ready), 32'(offer && !g));
      chk("ready1", 32'(req1_ready), 32'(offer && g));
      chk("math_start", 32'(math_start), 32'(cyc == startAt));
      chk("resp0_valid", 32'(resp0_valid), 32'(cyc == respAt && !respPort));
      chk("resp1_valid", 32'(resp1_valid), 32'(cyc == respAt && respPort));
      chk("resp0_res", 32'(resp0_res), 32'(mRes0));
      chk("resp1_res", 32'(resp1_res), 32'(mRes1));
      chk("math_a", 32'(math_a), 32'(mA));
      chk("math_b", 32'(math_b), 32'(mB));
      chk("arb_busy", 32'(arb_busy), 32'(!idle));
      chk("err_timeout", 32'(err_timeout), 32'(mErr));
      if (offer) begin
        mLast    = g;
        mA       = g ? req1_a : req0_a;
        mB       = g ? req1_b : req0_b;
        startAt  = cyc + 1;
        respPort = g;
        if (!cfgNever && cfgDelay <= BT) begin
          respAt  = startAt + cfgDelay + cfgLen + 1;
          pendRes = 16'(mA) * 16'(mB);
          pendErr = 1'b0;
        end else begin
          respAt  = startAt + BT + 1;
          pendRes = cfgNever ? 16'hBEEF : 16'(mA) * 16'(mB);
          pendErr = 1'b1;
        end
        freeAt = respAt;
      end
      // observation log of the DUT for the directed scenarios
      if (math_start) begin startCnt++; lastStartCyc = cyc; end
      if (hs0 || hs1) begin
        hsLog.push_back(hs1 ? 1 : 0);
        lastHsCyc = cyc;
        if (resp0_valid || resp1_valid) b2bCnt++;
      end
      if (req0_ready && req1_ready) bothRdyCnt++;
      if (req0_ready) rdy0Cnt++;
      if (resp0_valid) begin resp0Cnt++; lastResp0Cyc = cyc; end
      if (resp1_valid) begin resp1Cnt++; lastResp1Cyc = cyc; end
      if (err_timeout && !prevErr) errRiseCyc = cyc;
      prevErr = err_timeout;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push0(input int a, input int b);
    q0a.push_back(a); q0b.push_back(b);
  endtask

  task automatic push1(input int a, input int b);
    q1a.push_back(a); q1b.push_back(b);
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    tick();
    while ((q0a.size() > 0 || q1a.size() > 0 || req0_valid || req1_valid || arb_busy || math_busy) && n < maxc) begin
      tick();
      n++;
    end
    chk(name, 32'(n < maxc), 1);
  endtask

  task automatic chkOutputsZero(input string tag);
    chk({tag, "_ready0"}, 32'(req0_ready), 0);
    chk({tag, "_start"}, 32'(math_start), 0);
    chk({tag, "_math_a"}, 32'(math_a), 0);
    chk({tag, "_math_b"}, 32'(math_b), 0);
    chk({tag, "_resp0_valid"}, 32'(resp0_valid), 0);
    chk({tag, "_resp0_res"}, 32'(resp0_res), 0);
    chk({tag, "_resp1_res"}, 32'(resp1_res), 0);
    chk({tag, "_err"}, 32'(err_timeout), 0);
    chk({tag, "_arb_busy"}, 32'(arb_busy), 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- directed + random scenarios ----------------
  initial begin
    int s0, r0, r1, b0, base, n;
    int fairExp[6];
    fairExp = '{0, 1, 0, 1, 0, 1};
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    math_busy = 1'b0; math_res = '0;
    #1 rst_n = 1'b0;
    #1;
    chkOutputsZero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // single job on port 0: 3*5
    s0 = startCnt; r1 = resp1Cnt;
    push0(3, 5);
    drain("single_drain", 60);
    chk("single_start_latency", 32'(lastStartCyc - lastHsCyc), 1);
    chk("single_resp_latency", 32'(lastResp0Cyc - lastStartCyc), 5);
    chk("single_res", 32'(resp0_res), 15);
    chk("single_start_count", 32'(startCnt - s0), 1);
    chk("single_no_resp1", 32'(resp1Cnt - r1), 0);

    // contention straight out of reset: port 0 first
    doReset();
    s0 = startCnt; base = hsLog.size();
    push0(2, 7);
    push1(4, 4);
    drain("contend_drain", 80);
    chk("contend_hs_count", 32'(hsLog.size() - base), 2);
    chk("contend_first", 32'(hsLog[base]), 0);
    chk("contend_second", 32'(hsLog[base + 1]), 1);
    chk("contend_res0", 32'(resp0_res), 14);
    chk("contend_res1", 32'(resp1_res), 16);
    chk("contend_starts", 32'(startCnt - s0), 2);

    // fairness with both ports continuously valid for six jobs
    base = hsLog.size(); b0 = b2bCnt;
    for (int i = 0; i < 3; i++) begin
      push0(10 + i, 3);
      push1(20 + i, 2);
    end
    drain("fair_drain", 200);
    chk("fair_hs_count", 32'(hsLog.size() - base), 6);
    for (int i = 0; i < 6; i++) chk("fair_order", 32'(hsLog[base + i]), 32'(fairExp[i]));
    chk("fair_back_to_back", 32'(b2bCnt - b0), 5);
    chk("never_both_ready", 32'(bothRdyCnt), 0);

    // busy rises on the last permitted cycle: no timeout
    cfgDelay = BT; cfgLen = 2;
    push1(9, 9);
    drain("late_busy_drain", 60);
    chk("late_busy_res", 32'(resp1_res), 81);
    chk("late_busy_latency", 32'(lastResp1Cyc - lastStartCyc), 7);
    chk("late_busy_no_err", 32'(err_timeout), 0);

    // unit never raises busy
    cfgNever = 1'b1;
    push0(1, 1);
    drain("timeout_drain", 60);
    chk("timeout_err_latency", 32'(errRiseCyc - lastStartCyc), 5);
    chk("timeout_resp_with_err", 32'(lastResp0Cyc), 32'(errRiseCyc));
    chk("timeout_res", 32'(resp0_res), 32'h0000BEEF);
    cfgNever = 1'b0; cfgDelay = 1; cfgLen = 6;

    // port 1 pulses valid once while a port 0 job runs
    s0 = startCnt; r1 = resp1Cnt;
    push0(5, 5);
    n = 0;
    while (!arb_busy && n < 20) begin tick(); n++; end
    chk("cancel_wait_busy", 32'(n < 20), 1);
    push1(7, 7);
    tick();
    q1a.delete(); q1b.delete();
    drain("cancel_drain", 60);
    chk("cancel_starts", 32'(startCnt - s0), 1);
    chk("cancel_no_resp1", 32'(resp1Cnt - r1), 0);
    chk("cancel_res0", 32'(resp0_res), 25);
    chk("err_sticky", 32'(err_timeout), 1);

    // reset in the middle of a running job, unit stays busy afterwards
    push1(3, 3);
    n = 0;
    while (!(math_busy && arb_busy) && n < 20) begin tick(); n++; end
    chk("midreset_wait_run", 32'(n < 20), 1);
    tick();
    forceBusy = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chkOutputsZero("midreset");
    chk("midreset_resp1_valid", 32'(resp1_valid), 0);
    tick();
    tick();
    rst_n = 1'b1;
    r0 = resp0Cnt; r1 = resp1Cnt; n = rdy0Cnt;
    push0(6, 7);
    repeat (4) tick();
    chk("midreset_ready_held", 32'(rdy0Cnt - n), 0);
    chk("midreset_no_resp1", 32'(resp1Cnt - r1), 0);
    forceBusy = 1'b0;
    drain("midreset_drain", 60);
    chk("midreset_resp0_count", 32'(resp0Cnt - r0), 1);
    chk("midreset_res", 32'(resp0_res), 42);

    // random traffic with random unit timing
    for (int it = 0; it < 30; it++) begin
      cfgDelay = $urandom_range(1, BT);
      cfgLen   = $urandom_range(1, 4);
      cfgNever = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 1) == 1) push1($urandom_range(0, 255), $urandom_range(0, 255));
        else push0($urandom_range(0, 255), $urandom_range(0, 255));
        repeat ($urandom_range(0, 3)) tick();
      end
      drain("random_drain", 200);
    end
    chk("random_never_both_ready", 32'(bothRdyCnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
